// File: rtl/score_display_pkg.sv
// score_display_pkg: glyph codes, sequencer states and the active-player scan helper
// shared by the score display sequencer and its leader finder.
package score_display_pkg;

    localparam logic [3:0] GLYPH_OFF  = 4'd10;
    localparam logic [3:0] GLYPH_P    = 4'd11;
    localparam logic [3:0] GLYPH_DASH = 4'd12;

    typedef enum logic [1:0] {IDLE, BLINK, DISPLAY, LEADER} state_t;

    // First set bit strictly after cur, wrapping over 9 slots; cur itself if it is the only one.
    function automatic logic [3:0] next_active(input logic [8:0] mask, input logic [3:0] cur);
        logic [3:0] w_nxt;
        w_nxt = cur;
        for (int i = 9; i >= 1; i--)
            if (mask[(int'(cur) + i) % 9]) w_nxt = 4'((int'(cur) + i) % 9);
        return w_nxt;
    endfunction

    function automatic logic [3:0] digit(input logic [3:0] n);
        return (n > 4'd9) ? GLYPH_DASH : n;
    endfunction

endpackage

// File: rtl/score_leader_finder.sv
// score_leader_finder: combinational strict-maximum search over packed BCD scores.
// Only compiled when SCORE_DISPLAY_LEADER_EN is defined.
`ifdef SCORE_DISPLAY_LEADER_EN
module score_leader_finder #(
    parameter int NUM_PLAYERS = 2
) (
    input  logic [4*NUM_PLAYERS-1:0] i_tens,
    input  logic [4*NUM_PLAYERS-1:0] i_ones,
    output logic [3:0]               o_idx,
    output logic                     o_tie
);

    logic [7:0] w_max;
    logic [3:0] w_cnt;

    always_comb begin
        w_max = '0;
        o_idx = '0;
        w_cnt = '0;
        for (int k = 0; k < NUM_PLAYERS; k++)
            if ({i_tens[4*k +: 4], i_ones[4*k +: 4]} > w_max) begin
                w_max = {i_tens[4*k +: 4], i_ones[4*k +: 4]};
                o_idx = 4'(k);
            end
        for (int k = 0; k < NUM_PLAYERS; k++)
            if ({i_tens[4*k +: 4], i_ones[4*k +: 4]} == w_max) w_cnt = w_cnt + 4'd1;
        o_tie = w_cnt > 4'd1;
    end

endmodule
`endif

// File: rtl/score_display_sequencer.sv
// score_display_sequencer: cycles the shared 2-digit display over active players (blink "Pn", then score).
// Define SCORE_DISPLAY_LEADER_EN to add a leader screen at the wrap point.
module score_display_sequencer
    import score_display_pkg::*;
#(
    parameter int NUM_PLAYERS   = 2,
    parameter int BLINK_TIME    = 500,
    parameter int DISPLAY_TIME  = 2000,
    parameter int BLINK_TOGGLES = 4,
    parameter int TIMER_W       = 12
) (
    input  logic                     clk_1khz,
    input  logic                     rst_i,
    input  logic                     hold_i,
    input  logic [NUM_PLAYERS-1:0]   active_i,
    input  logic [4*NUM_PLAYERS-1:0] tens_i,
    input  logic [4*NUM_PLAYERS-1:0] ones_i,
    output logic [3:0]               tens_o,
    output logic [3:0]               ones_o,
    output logic [3:0]               player_o
);

    localparam logic [TIMER_W-1:0] BLINK_LAST = TIMER_W'(BLINK_TIME - 1);
    localparam logic [TIMER_W-1:0] DISP_LAST  = TIMER_W'(DISPLAY_TIME - 1);
    localparam logic [3:0]         TOG_LAST   = 4'(BLINK_TOGGLES - 1);

    state_t             r_state, w_state_nx;
    logic [TIMER_W-1:0] r_timer, w_timer_nx;
    logic [3:0]         r_interval, w_interval_nx;
    logic [3:0]         r_cur, w_cur_nx;
    logic [3:0]         w_tens_nx, w_ones_nx, w_player_nx;
    logic [8:0]         w_mask;
    logic [3:0]         w_first, w_next, w_tgt, w_sel_tens, w_sel_ones;
    logic               w_go;

    assign w_mask     = 9'(active_i);
    assign w_first    = next_active(w_mask, 4'd8);
    assign w_next     = next_active(w_mask, r_cur);
    assign w_sel_tens = digit(tens_i[4*r_cur +: 4]);
    assign w_sel_ones = digit(ones_i[4*r_cur +: 4]);

`ifdef SCORE_DISPLAY_LEADER_EN
    logic [3:0] w_lead_idx, w_lead_tens, w_lead_ones;
    logic       w_lead_tie;

    score_leader_finder #(.NUM_PLAYERS(NUM_PLAYERS)) u_leader (
        .i_tens (tens_i),
        .i_ones (ones_i),
        .o_idx  (w_lead_idx),
        .o_tie  (w_lead_tie)
    );

    assign w_lead_tens = w_lead_tie ? GLYPH_DASH : GLYPH_P;
    assign w_lead_ones = w_lead_tie ? GLYPH_DASH : 4'(w_lead_idx + 4'd1);
`endif

    always_comb begin
        w_state_nx    = r_state;
        w_timer_nx    = r_timer;
        w_interval_nx = r_interval;
        w_cur_nx      = r_cur;
        w_tens_nx     = tens_o;
        w_ones_nx     = ones_o;
        w_player_nx   = player_o;
        w_go          = 1'b0;
        w_tgt         = w_first;
        if (!hold_i) begin
            case (r_state)
                IDLE: w_go = w_mask != '0;
                BLINK: begin
                    w_timer_nx = r_timer + 1'b1;
                    if (r_timer == BLINK_LAST) begin
                        w_timer_nx = '0;
                        if (r_interval == TOG_LAST) begin
                            w_state_nx = DISPLAY;
                            w_tens_nx  = w_sel_tens;
                            w_ones_nx  = w_sel_ones;
                        end else begin
                            w_interval_nx = r_interval + 4'd1;
                            w_tens_nx     = w_interval_nx[0] ? GLYPH_OFF : GLYPH_P;
                            w_ones_nx     = w_interval_nx[0] ? GLYPH_OFF : 4'(r_cur + 4'd1);
                        end
                    end
                end
                DISPLAY: begin
                    w_timer_nx = r_timer + 1'b1;
                    w_tens_nx  = w_sel_tens;
                    w_ones_nx  = w_sel_ones;
                    if (r_timer == DISP_LAST) begin
                        w_timer_nx = '0;
                        w_tgt      = w_next;
                        if (w_mask == '0) begin
                            w_state_nx  = IDLE;
                            w_tens_nx   = GLYPH_OFF;
                            w_ones_nx   = GLYPH_OFF;
                            w_player_nx = '0;
                        end
`ifdef SCORE_DISPLAY_LEADER_EN
                        else if (w_next <= r_cur) begin
                            w_state_nx = LEADER;
                            w_tens_nx  = w_lead_tens;
                            w_ones_nx  = w_lead_ones;
                        end
`endif
                        else w_go = 1'b1;
                    end
                end
`ifdef SCORE_DISPLAY_LEADER_EN
                LEADER: begin
                    w_timer_nx = r_timer + 1'b1;
                    w_tens_nx  = w_lead_tens;
                    w_ones_nx  = w_lead_ones;
                    if (r_timer == DISP_LAST) begin
                        w_timer_nx = '0;
                        if (w_mask == '0) begin
                            w_state_nx  = IDLE;
                            w_tens_nx   = GLYPH_OFF;
                            w_ones_nx   = GLYPH_OFF;
                            w_player_nx = '0;
                        end else w_go = 1'b1;
                    end
                end
`endif
                default: w_state_nx = IDLE;
            endcase
            // Common entry into the blink phase of the player chosen above.
            if (w_go) begin
                w_state_nx    = BLINK;
                w_timer_nx    = '0;
                w_interval_nx = '0;
                w_cur_nx      = w_tgt;
                w_player_nx   = w_tgt;
                w_tens_nx     = GLYPH_P;
                w_ones_nx     = 4'(w_tgt + 4'd1);
            end
        end
    end

    always_ff @(posedge clk_1khz or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_timer    <= '0;
            r_interval <= '0;
            r_cur      <= '0;
            tens_o     <= GLYPH_OFF;
            ones_o     <= GLYPH_OFF;
            player_o   <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_timer    <= w_timer_nx;
            r_interval <= w_interval_nx;
            r_cur      <= w_cur_nx;
            tens_o     <= w_tens_nx;
            ones_o     <= w_ones_nx;
            player_o   <= w_player_nx;
        end
    end

endmodule

// File: tb/tb_score_display_sequencer.sv
// tb_score_display_sequencer: directed table, corner sequences and a randomized run
// against a period-position model of the score display sequencer.
module tb_score_display_sequencer;

    localparam int NP     = 3;
    localparam int BT     = 4;
    localparam int DT     = 8;
    localparam int TOG    = 4;
    localparam int PERIOD = TOG * BT + DT;
`ifdef SCORE_DISPLAY_LEADER_EN
    localparam bit LEAD = 1'b1;
`else
    localparam bit LEAD = 1'b0;
`endif

    typedef struct {
        int cyc;
        int t;
        int o;
        int p;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            hold = 1'b0;
    logic [NP-1:0]   active = '0;
    logic [4*NP-1:0] tens = '0;
    logic [4*NP-1:0] ones = '0;
    logic [3:0]      tens_o, ones_o, player_o;

    int checks = 0;
    int failures = 0;
    int m_mode, m_cur, m_pos;
    int exp_t, exp_o, exp_p;
    vec_t tbl[13];

    score_display_sequencer #(
        .NUM_PLAYERS   (NP),
        .BLINK_TIME    (BT),
        .DISPLAY_TIME  (DT),
        .BLINK_TOGGLES (TOG),
        .TIMER_W       (12)
    ) dut (
        .clk_1khz (clk),
        .rst_i    (rst),
        .hold_i   (hold),
        .active_i (active),
        .tens_i   (tens),
        .ones_i   (ones),
        .tens_o   (tens_o),
        .ones_o   (ones_o),
        .player_o (player_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    task automatic check3(input string name, input int t, input int o, input int p);
        check({name, "_tens"}, int'(tens_o), t);
        check({name, "_ones"}, int'(ones_o), o);
        check({name, "_player"}, int'(player_o), p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int nib(input logic [4*NP-1:0] v, input int k);
        return int'(v[4*k +: 4]);
    endfunction

    function automatic int dig(input int n);
        return (n > 9) ? 12 : n;
    endfunction

    function automatic int lowest_player();
        for (int k = 0; k < NP; k++) if (active[k]) return k;
        return 0;
    endfunction

    function automatic int next_player(input int cur);
        for (int i = 1; i <= NP; i++) if (active[(cur + i) % NP]) return (cur + i) % NP;
        return cur;
    endfunction

    // Reference: which screen is shown follows from the position inside the current player period.
    task automatic model_edge();
        int nx, best, idx, cnt, s;
        if (hold) return;
        case (m_mode)
            0: if (active != 0) begin
                m_mode = 1;
                m_pos  = 0;
                m_cur  = lowest_player();
            end
            1: begin
                m_pos++;
                if (m_pos == PERIOD) begin
                    m_pos = 0;
                    if (active == 0) m_mode = 0;
                    else begin
                        nx = next_player(m_cur);
                        if (LEAD && nx <= m_cur) m_mode = 2;
                        else m_cur = nx;
                    end
                end
            end
            default: begin
                m_pos++;
                if (m_pos == DT) begin
                    m_pos = 0;
                    if (active == 0) m_mode = 0;
                    else begin
                        m_mode = 1;
                        m_cur  = lowest_player();
                    end
                end
            end
        endcase
        if (m_mode == 0) begin
            exp_t = 10; exp_o = 10; exp_p = 0;
        end else if (m_mode == 1) begin
            exp_p = m_cur;
            if (m_pos < TOG * BT) begin
                exp_t = ((m_pos / BT) % 2 == 0) ? 11 : 10;
                exp_o = ((m_pos / BT) % 2 == 0) ? m_cur + 1 : 10;
            end else begin
                exp_t = dig(nib(tens, m_cur));
                exp_o = dig(nib(ones, m_cur));
            end
        end else begin
            best = -1; idx = 0; cnt = 0;
            for (int k = 0; k < NP; k++) begin
                s = nib(tens, k) * 16 + nib(ones, k);
                if (s > best) begin best = s; idx = k; end
            end
            for (int k = 0; k < NP; k++) if (nib(tens, k) * 16 + nib(ones, k) == best) cnt++;
            exp_t = (cnt > 1) ? 12 : 11;
            exp_o = (cnt > 1) ? 12 : idx + 1;
        end
    endtask

    initial begin
        int n;
        tbl = '{'{1, 11, 1, 0}, '{4, 11, 1, 0}, '{5, 10, 10, 0}, '{8, 10, 10, 0},
                '{9, 11, 1, 0}, '{13, 10, 10, 0}, '{16, 10, 10, 0}, '{17, 4, 2, 0},
                '{24, 4, 2, 0}, '{25, 11, 2, 1}, '{41, 0, 7, 1}, '{48, 0, 7, 1},
                '{49, 11, 1, LEAD ? 1 : 0}};

        // P1=42, P2=07 with players 1 and 2 active
        active = 3'b011;
        tens = 12'h004;
        ones = 12'h072;
        do_reset();
        check3("reset", 10, 10, 0);
        for (int c = 1; c <= 49; c++) begin
            step();
            foreach (tbl[i]) if (tbl[i].cyc == c) check3($sformatf("seq_c%0d", c), tbl[i].t, tbl[i].o, tbl[i].p);
        end

        // Players 1 and 3: player 2 never shown; clearing the mask ends in IDLE after P3
        active = 3'b101;
        tens = 12'h305;
        ones = 12'h109;
        do_reset();
        for (int c = 1; c <= 48; c++) begin
            step();
            check($sformatf("skip_player_c%0d", c), int'(player_o), (c < 25) ? 0 : 2);
            if (c == 42) active = 3'b000;
        end
        step();
        check3("idle_after_clear", 10, 10, 0);
        repeat (5) step();
        check3("idle_stays", 10, 10, 0);

        // Hold mid-blink freezes everything, remaining interval preserved
        active = 3'b001;
        tens = 12'h004;
        ones = 12'h002;
        do_reset();
        step();
        step();
        check3("pre_hold", 11, 1, 0);
        hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check3($sformatf("held_%0d", i), 11, 1, 0);
        end
        hold = 1'b0;
        n = 0;
        while (tens_o != 4'd10 && n < 10) begin
            step();
            n++;
        end
        check("hold_remaining_edges", n, 3);

        // Out-of-range nibble shows dash one cycle later
        n = 0;
        while (tens_o != 4'd4 && n < 40) begin
            step();
            n++;
        end
        check("reach_display", int'(tens_o), 4);
        tens = 12'h00C;
        ones = 12'h005;
        check("dash_lag_old", int'(tens_o), 4);
        step();
        check3("dash", 12, 5, 0);

        // Asynchronous reset between edges during DISPLAY
        #3;
        rst = 1'b1;
        #1;
        check3("async_reset", 10, 10, 0);
        step();
        check3("reset_held", 10, 10, 0);
        #2;
        rst = 1'b0;
        step();
        check3("restart", 11, 1, 0);

`ifdef SCORE_DISPLAY_LEADER_EN
        // Leader: 15/30/30 ties, then P3=31 wins
        active = 3'b111;
        tens = 12'h331;
        ones = 12'h005;
        do_reset();
        for (int c = 1; c <= 153; c++) begin
            step();
            if (c == 73) check3("leader_tie", 12, 12, 2);
            if (c == 80) check3("leader_tie_end", 12, 12, 2);
            if (c == 81) check3("after_leader", 11, 1, 0);
            if (c == 100) ones = 12'h105;
            if (c == 153) check3("leader_p3", 11, 3, 2);
        end
`endif

        // Randomized run against the reference model
        active = 3'b011;
        do_reset();
        m_mode = 0; m_cur = 0; m_pos = 0;
        exp_t = 10; exp_o = 10; exp_p = 0;
        for (int i = 0; i < 3000; i++) begin
            model_edge();
            step();
            check3($sformatf("rand_%0d", i), exp_t, exp_o, exp_p);
            hold = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) active = 3'($urandom);
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < NP; k++) begin
                    tens[4*k +: 4] = 4'($urandom_range(0, 11));
                    ones[4*k +: 4] = 4'($urandom_range(0, 11));
                end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_display_sequencer.md
# score_display_sequencer

Parametrised multi-player score sequencer for the shared two-digit 7-segment display. It cycles over up to 9 players. For each active player it blinks the "P<n>" tag, then shows that player's two-digit BCD score. Inactive players are skipped, and the sequence can be paused. It sits between the per-player score counters and the BCD/glyph-to-segment decoder, in the 1 kHz clock domain.

## Interface
- NUM_PLAYERS, 2: player count, legal 2..9
- BLINK_TIME, 500: cycles per blink interval (on or off)
- DISPLAY_TIME, 2000: cycles the score is shown
- BLINK_TOGGLES, 4: blink intervals per player, even, 2..14; interval 0 is ON
- TIMER_W, 12: timer width; must hold max(BLINK_TIME, DISPLAY_TIME)-1
- clk_1khz  in  1  1 kHz clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- hold_i  in  1  pause: timer and state frozen, outputs held
- active_i  in  NUM_PLAYERS  player enable mask, bit k = player k+1
- tens_i  in  4*NUM_PLAYERS  packed BCD tens, player k at [4k+3:4k]
- ones_i  in  4*NUM_PLAYERS  packed BCD ones, same packing
- tens_o  out  4  glyph code, left digit (0-9 digit, 10 OFF, 11 'P', 12 dash)
- ones_o  out  4  glyph code, right digit
- player_o  out  4  index of player being shown (0-based), 0 in IDLE

## Operation
- States:
  - IDLE: entered from reset, and whenever no player is active at a player boundary.
  - BLINK: blink phase of the current player.
  - DISPLAY: score display of the current player.
  - LEADER: only with the macro defined.
- IDLE: outputs OFF/OFF. On the first edge with active_i != 0, move to BLINK with cur = lowest set bit, timer = 0, interval = 0.
- BLINK: one interval lasts BLINK_TIME cycles (timer 0..BLINK_TIME-1).
  - Even interval: tens_o=11, ones_o=cur+1.
  - Odd interval: OFF/OFF.
  - After interval BLINK_TOGGLES-1 completes, move to DISPLAY with timer = 0.
- DISPLAY: tens_o/ones_o follow the selected tens_i/ones_i live (registered, 1-cycle lag). Any input nibble >9 is replaced by 12 (dash).
  - After DISPLAY_TIME cycles, cur advances to the next set bit of active_i above cur, wrapping around. Then move to BLINK.
  - If active_i == 0 at that point, move to IDLE.
  - Only cur is re-evaluated if it is the sole active bit, so the same player repeats.
- active_i is sampled only at player boundaries. Clearing the current player's bit mid-sequence does not abort its sequence.
- hold_i has priority over all advancement. On release, the sequence resumes at the same timer value.
- Reset mid-operation: immediate return to IDLE and OFF outputs. No partial sequence is resumed.

## Timing
- Reset values: tens_o=10, ones_o=10, player_o=0, timer=0, interval=0, state IDLE.
- Outputs are registers. State-derived glyphs (P/n/OFF) change on the same edge as the state/interval change. Score glyphs lag their inputs by 1 cycle.
- From leaving IDLE, one player period is BLINK_TOGGLES*BLINK_TIME + DISPLAY_TIME cycles. With defaults that is 4000.
- player_o updates on the edge entering BLINK for the new player.
- Timer compare is TIMER_W bits, unsigned. The timer never exceeds its phase limit minus 1.

## Configuration
- SCORE_DISPLAY_LEADER_EN defined: after the DISPLAY of the highest-indexed active player (the wrap point), insert LEADER for DISPLAY_TIME cycles, then BLINK the lowest active player.
  - LEADER shows the player with the strictly greatest score: tens_o=11, ones_o=index+1.
  - Scores compare as {tens,ones}, unsigned 8-bit.
  - A tie for the maximum shows 12/12. player_o holds the last value.
- Macro undefined: no LEADER state and no comparator logic. The sequence wraps directly.

## Structure
- Package score_display_pkg holds:
  - glyph constants GLYPH_OFF=10, GLYPH_P=11, GLYPH_DASH=12
  - state enum IDLE/BLINK/DISPLAY/LEADER
  - a next_active(mask, cur) function
- Sub-module score_leader_finder: combinational max/tie over the packed scores. Instantiated only under SCORE_DISPLAY_LEADER_EN.

## Test plan
Bench parameters: BLINK_TIME=4, DISPLAY_TIME=8, BLINK_TOGGLES=4, NUM_PLAYERS=3.
- Reset with active_i=3'b011 and scores P1=42, P2=07:
  - cycles 1-4 show 11/1, cycles 5-8 show 10/10, repeating through cycle 16
  - then 8 cycles of 4/2
  - then P2 blinks 11/2 and shows 0/7
  - then P1 again
- active_i=3'b101: the P2 sequence is never shown; player_o alternates 0, 2. Setting active_i=0 during P3's DISPLAY leads to IDLE with 10/10 after that DISPLAY ends.
- hold_i high for 20 cycles mid-BLINK: outputs and player_o frozen. After release, the remaining interval length equals the length left before the hold.
- tens_i nibble=4'hC during DISPLAY: tens_o=12 one cycle later.
- rst_i asserted asynchronously between clock edges during DISPLAY: outputs 10/10 immediately, and the sequence restarts from IDLE.
- With SCORE_DISPLAY_LEADER_EN, scores 15/30/30: LEADER shows 12/12. Change P3 to 31: LEADER shows 11/3.
